// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART TX byte interface
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ*DW-1:0] i_data,
  input  logic [N_REQ-1:0]    i_last,
  output logic [N_REQ-1:0]    o_ack,
  output logic [N_REQ-1:0]    o_grant,
  output logic                o_busy,
  output logic                o_abort,
  output logic                o_tx_valid,
  output logic [DW-1:0]       o_tx_data,
  input  logic                i_tx_ready
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_d;
  logic             busy_d, abort_d;

  logic [PW-1:0]    own_idx, next_ptr, pick_idx;
  logic             pick_found, owner_req, owner_last, ack_fire;

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (o_grant[i]) own_idx = PW'(i);
    end
  end

  assign next_ptr = (own_idx == PW'(N_REQ-1)) ? '0 : own_idx + 1'b1;

  // Scan requesters starting at ptr so the last owner goes to the back of the line
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found && i_req[(int'(ptr_q) + i) % N_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  assign owner_req  = |(o_grant & i_req);
  assign owner_last = |(o_grant & i_last);
  assign o_tx_valid = (state_q == OWN) && owner_req;
  assign o_tx_data  = o_tx_valid ? i_data[int'(own_idx)*DW +: DW] : '0;
  assign ack_fire   = o_tx_valid && i_tx_ready;
  assign o_ack      = ack_fire ? o_grant : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = o_grant;
    busy_d  = o_busy;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick_found) begin
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          busy_d  = 1'b1;
          state_d = OWN;
        end
      end
      OWN: begin
        if (ack_fire) begin
          cnt_d = '0;
          if (owner_last) begin
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = next_ptr;
            state_d = IDLE;
          end
        end else if (owner_req) begin
          cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT-1)) begin
          // Owner stalled for TIMEOUT cycles: revoke and move on
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      o_grant <= '0;
      o_busy  <= 1'b0;
      o_abort <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      o_grant <= grant_d;
      o_busy  <= busy_d;
      o_abort <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - table-driven bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, last, ack, grant;
  logic [N*DW-1:0] data;
  logic          busy, abort_p, tx_valid, tx_ready;
  logic [DW-1:0] tx_data;

  int errors = 0;
  int checks = 0;

  uart_tx_arbiter #(.N_REQ(N), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .i_last(last),
    .o_ack(ack), .o_grant(grant), .o_busy(busy), .o_abort(abort_p),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  last;
    logic        rdy;
    logic [3:0]  grant;
    logic        busy;
    logic        valid;
    logic [7:0]  txd;
    logic [3:0]  ack;
    logic        abort_p;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l, input logic rd,
                     input logic [3:0] g, input logic b, input logic v, input logic [7:0] t,
                     input logic [3:0] a, input logic ab);
    vec_t x;
    x.req = r; x.data = d; x.last = l; x.rdy = rd;
    x.grant = g; x.busy = b; x.valid = v; x.txd = t; x.ack = a; x.abort_p = ab;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] g, input logic b, input logic v,
                            input logic [7:0] t, input logic [3:0] a, input logic ab);
    chk({tag, " grant"}, 32'(grant), 32'(g));
    chk({tag, " busy"},  32'(busy), 32'(b));
    chk({tag, " valid"}, 32'(tx_valid), 32'(v));
    chk({tag, " data"},  32'(tx_data), 32'(t));
    chk({tag, " ack"},   32'(ack), 32'(a));
    chk({tag, " abort"}, 32'(abort_p), 32'(ab));
  endtask

  task automatic step(input logic [3:0] r, input logic [31:0] d, input logic [3:0] l, input logic rd);
    @(posedge clk);
    #1;
    req = r; data = d; last = l; tx_ready = rd;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; data = '0; last = '0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 4'b0, 1'b0, 1'b0, 8'h0, 4'b0, 1'b0);
    rst = 1'b0;

    // single requester, 3-byte packet
    add(4'b0010, 32'h0000A100, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b0010, 32'h0000A100, 4'b0000, 1, 4'b0010, 1, 1, 8'hA1, 4'b0010, 0);
    add(4'b0010, 32'h0000A200, 4'b0000, 1, 4'b0010, 1, 1, 8'hA2, 4'b0010, 0);
    add(4'b0010, 32'h0000A300, 4'b0010, 1, 4'b0010, 1, 1, 8'hA3, 4'b0010, 0);
    add(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    // everyone requests 1-byte packets; ptr is 2 after the packet above
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0100, 1, 1, 8'h12, 4'b0100, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b1000, 1, 1, 8'h13, 4'b1000, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0001, 1, 1, 8'h10, 4'b0001, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0010, 1, 1, 8'h11, 4'b0010, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b1111, 32'h13121110, 4'b1111, 1, 4'b0100, 1, 1, 8'h12, 4'b0100, 0);
    // requester 3 completes, then 0 and 2 together: pointer wraps to 0
    add(4'b1000, 32'h13121110, 4'b1000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b1000, 32'h13121110, 4'b1000, 1, 4'b1000, 1, 1, 8'h13, 4'b1000, 0);
    add(4'b0101, 32'h13121110, 4'b0101, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    add(4'b0101, 32'h13121110, 4'b0101, 1, 4'b0001, 1, 1, 8'h10, 4'b0001, 0);
    add(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    // backpressure: 5 stalled cycles then one ack
    add(4'b0100, 32'h00550000, 4'b0100, 0, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    for (int i = 0; i < 5; i++)
      add(4'b0100, 32'h00550000, 4'b0100, 0, 4'b0100, 1, 1, 8'h55, 4'b0000, 0);
    add(4'b0100, 32'h00550000, 4'b0100, 1, 4'b0100, 1, 1, 8'h55, 4'b0100, 0);
    add(4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].data, vecs[i].last, vecs[i].rdy);
      check_outs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].busy, vecs[i].valid,
                 vecs[i].txd, vecs[i].ack, vecs[i].abort_p);
    end

    // timeout: owner 3 sends a non-last byte then goes quiet while 1 waits
    step(4'b1000, 32'h77000000, 4'b0000, 1);
    check_outs("to_idle", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    step(4'b1000, 32'h77000000, 4'b0000, 1);
    check_outs("to_byte", 4'b1000, 1, 1, 8'h77, 4'b1000, 0);
    for (int i = 0; i < TO; i++) begin
      step(4'b0010, 32'h00008800, 4'b0010, 1);
      check_outs($sformatf("to_wait%0d", i), 4'b1000, 1, 0, 8'h00, 4'b0000, 0);
    end
    step(4'b0010, 32'h00008800, 4'b0010, 1);
    check_outs("to_abort", 4'b0000, 0, 0, 8'h00, 4'b0000, 1);
    step(4'b0010, 32'h00008800, 4'b0010, 1);
    check_outs("to_next", 4'b0010, 1, 1, 8'h88, 4'b0010, 0);
    step(4'b0000, 32'h00000000, 4'b0000, 1);
    check_outs("to_done", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);

    // asynchronous reset during byte 2 of a packet from requester 2
    step(4'b0100, 32'h00C10000, 4'b0000, 1);
    step(4'b0100, 32'h00C10000, 4'b0000, 1);
    check_outs("rst_b1", 4'b0100, 1, 1, 8'hC1, 4'b0100, 0);
    step(4'b0101, 32'h00C2005A, 4'b0000, 1);
    check_outs("rst_b2", 4'b0100, 1, 1, 8'hC2, 4'b0100, 0);
    #2 rst = 1'b1;
    #1 check_outs("rst_async", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    @(negedge clk);
    check_outs("rst_hold", 4'b0000, 0, 0, 8'h00, 4'b0000, 0);
    rst = 1'b0;
    @(negedge clk);
    check_outs("rst_regrant", 4'b0001, 1, 1, 8'h5A, 4'b0001, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter byte interface between N requesters: key handler, status reporter, debug echo, and so on.
- Grants the transmitter to one requester for a whole packet. The packet is bounded by a last-byte flag.
- Sits between the application modules and the UART TX serializer on the kit.
- Releases a stalled owner after a configurable idle timeout.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, byte width.
- TIMEOUT, 1000, clock cycles the owner may leave i_req low mid-packet before its grant is revoked (>=2).

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req  in  N_REQ  per-requester byte-valid; held until acked.
- i_data  in  N_REQ*DW  packed bytes; requester k occupies bits [k*DW +: DW].
- i_last  in  N_REQ  per-requester "this byte ends the packet"; qualified by i_req.
- o_ack  out  N_REQ  per-requester byte-accepted pulse.
- o_grant  out  N_REQ  one-hot current owner, registered.
- o_busy  out  1  high while any grant is held, registered.
- o_abort  out  1  one-cycle pulse when a grant is revoked by timeout, registered.
- o_tx_valid  out  1  byte valid toward the serializer.
- o_tx_data  out  DW  byte toward the serializer.
- i_tx_ready  in  1  serializer can accept a byte this cycle.

Behaviour:
- Reset (asynchronous, i_rst=1):
  - state=IDLE, priority pointer ptr=0, idle counter=0.
  - o_grant=0, o_busy=0, o_abort=0, o_ack=0, o_tx_valid=0, o_tx_data=0.
  - Reset mid-packet drops the grant immediately; no byte is acked in that cycle.
- States:
  - IDLE, no owner:
    - If i_req != 0, select the first requester k scanning ptr, ptr+1, ... modulo N_REQ.
    - Next edge: o_grant = one-hot(k), o_busy=1, state=OWN.
    - If i_req == 0, stay in IDLE.
  - OWN, owner g:
    - o_tx_valid = i_req[g] (combinational from registered grant).
    - o_tx_data = i_data slice g when o_tx_valid=1, else 0.
    - o_ack[g] = o_tx_valid & i_tx_ready; all other o_ack bits are 0.
    - Acked byte with i_last[g]=1: next edge sets o_grant=0, o_busy=0, ptr=(g+1) mod N_REQ, state=IDLE.
    - Acked byte with i_last[g]=0: stay in OWN.
- Latency:
  - Request in IDLE at cycle n → o_grant and o_tx_valid at cycle n+1.
  - Last byte acked at cycle m → IDLE at m+1 → next grant at m+2. One dead cycle between packets, always.
- Arbitration:
  - Requests from non-owners are ignored in OWN; no preemption.
  - Simultaneous requests in IDLE are resolved purely by ptr.
  - ptr changes only on normal packet completion or on abort.
- Backpressure:
  - With i_tx_ready=0, o_tx_valid and o_tx_data stay stable as long as the owner holds i_req and i_data.
  - Requesters must not change data or withdraw while unacked. This is a requester obligation; the arbiter does not check it.
- Timeout:
  - In OWN, the counter increments each cycle i_req[g]=0 and clears whenever i_req[g]=1 or on any ack.
  - When the counter reaches TIMEOUT-1 with i_req[g] still 0, the next edge:
    - clears the grant;
    - sets ptr=(g+1) mod N_REQ;
    - pulses o_abort=1 for exactly one cycle;
    - sets state=IDLE and clears the counter.
  - An abort therefore happens after TIMEOUT consecutive idle cycles.
  - Backpressure (i_req=1, i_tx_ready=0) never counts toward timeout.
- Widths: ptr is clog2(N_REQ) bits; the counter is clog2(TIMEOUT) bits and saturates, never wraps.
- Invariants: o_grant has at most one bit set; o_ack is nonzero only when o_busy=1.

Test Plan:
- Single requester:
  - Stimulus: req[1] sends 3 bytes 0xA1, 0xA2, 0xA3 (last on the third), i_tx_ready=1.
  - Response: o_grant=0010 one cycle after req; o_ack[1] on 3 consecutive cycles; o_tx_data sequence A1, A2, A3; o_busy falls the cycle after the third ack; ptr=2.
- Round-robin:
  - Stimulus: all four requesters each send a 1-byte packet, requests held continuously from reset.
  - Response: grant order 0,1,2,3, then 0 again; exactly one idle cycle between grants.
- Pointer wrap:
  - Stimulus: after requester 3 completes, req[0] and req[2] assert together.
  - Response: requester 0 is granted.
- Backpressure:
  - Stimulus: owner byte 0x55 with i_tx_ready=0 for 5 cycles, then 1.
  - Response: o_tx_valid=1 and o_tx_data=0x55 stable for all 6 cycles; a single o_ack pulse; o_abort stays 0.
- Timeout:
  - Stimulus: TIMEOUT=8; owner sends one non-last byte, then drops i_req.
  - Response: o_abort pulses exactly once, 8 cycles after the drop; o_grant=0 in the same cycle; the next waiting requester is granted one cycle later.
- Reset mid-packet:
  - Stimulus: assert i_rst asynchronously during byte 2 of a packet.
  - Response: all outputs read 0 immediately; after release, the first grant goes to requester 0 if it is requesting.
